// File: rtl/tq_round_clip_8.sv
// Eight-lane round / arithmetic-shift / saturate normaliser; TQ_ROUND_CLIP_SAT_CNT_EN adds a clip-beat counter.
// Latency: 2 cycles from input accept to o_valid; one beat per cycle sustained.
// Backpressure: full-pipeline stall while o_valid & !o_ready; i_ready = !o_valid | o_ready.
module tq_round_clip_8 #(
    parameter int IN_W  = 28,
    parameter int OUT_W = 16,
    parameter int SH_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [SH_W-1:0]         i_shift,
    input  logic signed [IN_W-1:0]  i_0,
    input  logic signed [IN_W-1:0]  i_1,
    input  logic signed [IN_W-1:0]  i_2,
    input  logic signed [IN_W-1:0]  i_3,
    input  logic signed [IN_W-1:0]  i_4,
    input  logic signed [IN_W-1:0]  i_5,
    input  logic signed [IN_W-1:0]  i_6,
    input  logic signed [IN_W-1:0]  i_7,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic signed [OUT_W-1:0] o_0,
    output logic signed [OUT_W-1:0] o_1,
    output logic signed [OUT_W-1:0] o_2,
    output logic signed [OUT_W-1:0] o_3,
    output logic signed [OUT_W-1:0] o_4,
    output logic signed [OUT_W-1:0] o_5,
    output logic signed [OUT_W-1:0] o_6,
    output logic signed [OUT_W-1:0] o_7,
    output logic                    o_sat
`ifdef TQ_ROUND_CLIP_SAT_CNT_EN
    ,
    input  logic                    i_sat_clr,
    output logic [15:0]             o_sat_cnt
`endif
);

    localparam int LANES = 8;
    localparam int X_W   = IN_W + 1;

    // Saturation bounds sign-extended to the stage-1 width.
    localparam logic signed [X_W-1:0] SMAX = {{(X_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [X_W-1:0] SMIN = {{(X_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0]  in_lane [LANES];
    logic                    advance;
    logic [31:0]             sh_req;
    logic [31:0]             sh_eff;
    logic [X_W-1:0]          rnd;
    logic signed [X_W-1:0]   sum     [LANES];
    logic signed [X_W-1:0]   s1_nxt  [LANES];

    logic                    s1_v;
    logic signed [X_W-1:0]   s1_x    [LANES];

    logic signed [OUT_W-1:0] sat_val [LANES];
    logic [LANES-1:0]        clip;

    logic signed [OUT_W-1:0] o_r     [LANES];

    assign in_lane[0] = i_0;
    assign in_lane[1] = i_1;
    assign in_lane[2] = i_2;
    assign in_lane[3] = i_3;
    assign in_lane[4] = i_4;
    assign in_lane[5] = i_5;
    assign in_lane[6] = i_6;
    assign in_lane[7] = i_7;

    assign advance = !o_valid || o_ready;
    assign i_ready = advance;

    // Shift amounts beyond the lane width clamp to IN_W-1.
    assign sh_req = 32'(i_shift);
    assign sh_eff = (sh_req > 32'(IN_W - 1)) ? 32'(IN_W - 1) : sh_req;
    assign rnd    = (sh_eff == 32'd0) ? '0 : (X_W'(1) << (sh_eff - 32'd1));

    // One guard bit keeps the rounding add from wrapping.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            sum[k]    = signed'({in_lane[k][IN_W-1], in_lane[k]}) + signed'(rnd);
            s1_nxt[k] = sum[k] >>> sh_eff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                s1_x[k] <= '0;
            end
        end else if (advance) begin
            s1_v <= i_valid;
            if (i_valid) begin
                for (int k = 0; k < LANES; k++) begin
                    s1_x[k] <= s1_nxt[k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            sat_val[k] = s1_x[k][OUT_W-1:0];
            clip[k]    = 1'b0;
            if (s1_x[k] > SMAX) begin
                sat_val[k] = {1'b0, {(OUT_W-1){1'b1}}};
                clip[k]    = 1'b1;
            end else if (s1_x[k] < SMIN) begin
                sat_val[k] = {1'b1, {(OUT_W-1){1'b0}}};
                clip[k]    = 1'b1;
            end
        end
    end

    // Output lanes and o_sat hold their last value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                o_r[k] <= '0;
            end
        end else if (advance) begin
            o_valid <= s1_v;
            if (s1_v) begin
                o_sat <= |clip;
                for (int k = 0; k < LANES; k++) begin
                    o_r[k] <= sat_val[k];
                end
            end
        end
    end

    assign o_0 = o_r[0];
    assign o_1 = o_r[1];
    assign o_2 = o_r[2];
    assign o_3 = o_r[3];
    assign o_4 = o_r[4];
    assign o_5 = o_r[5];
    assign o_6 = o_r[6];
    assign o_7 = o_r[7];

`ifdef TQ_ROUND_CLIP_SAT_CNT_EN
    // Counts clipped output transfers; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sat_cnt <= '0;
        end else if (i_sat_clr) begin
            o_sat_cnt <= '0;
        end else if (o_valid && o_ready && o_sat && (o_sat_cnt != 16'hFFFF)) begin
            o_sat_cnt <= o_sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tq_round_clip_8.sv
// Randomised and directed bench for tq_round_clip_8 against an arithmetic reference model.
module tb_tq_round_clip_8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_valid = 1'b0;
    logic               i_ready;
    logic [3:0]         i_shift = '0;
    logic signed [27:0] i_l [8];
    logic               o_valid;
    logic               o_ready = 1'b0;
    logic signed [15:0] o_l [8];
    logic               o_sat;
`ifdef TQ_ROUND_CLIP_SAT_CNT_EN
    logic               i_sat_clr = 1'b0;
    logic [15:0]        o_sat_cnt;
    int                 cnt_m = 0;
`endif

    int     npass = 0;
    int     ntot  = 0;
    longint q[$];
    int     lat;

    tq_round_clip_8 dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_shift(i_shift),
        .i_0(i_l[0]), .i_1(i_l[1]), .i_2(i_l[2]), .i_3(i_l[3]),
        .i_4(i_l[4]), .i_5(i_l[5]), .i_6(i_l[6]), .i_7(i_l[7]),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_0(o_l[0]), .o_1(o_l[1]), .o_2(o_l[2]), .o_3(o_l[3]),
        .o_4(o_l[4]), .o_5(o_l[5]), .o_6(o_l[6]), .o_7(o_l[7]),
        .o_sat(o_sat)
`ifdef TQ_ROUND_CLIP_SAT_CNT_EN
        , .i_sat_clr(i_sat_clr), .o_sat_cnt(o_sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // floor((x + rnd) / 2^sh) with the shift clamped to 27.
    function automatic longint rc(input longint x, input int sh);
        int     s;
        longint v;
        s = (sh > 27) ? 27 : sh;
        v = x + ((s == 0) ? 64'sd0 : (64'sd1 <<< (s - 1)));
        return v >>> s;
    endfunction

    // Scoreboard: 9 entries per beat (8 lanes then sat flag).
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            chk("rst_o_valid", o_valid, 0);
`ifdef TQ_ROUND_CLIP_SAT_CNT_EN
            cnt_m = 0;
`endif
        end else begin
            chk("i_ready", i_ready, !o_valid || o_ready);
`ifdef TQ_ROUND_CLIP_SAT_CNT_EN
            chk("sat_cnt", o_sat_cnt, cnt_m);
            if (i_sat_clr) cnt_m = 0;
            else if (o_valid && o_ready && o_sat && cnt_m < 65535) cnt_m++;
`endif
            if (o_valid) begin
                if (q.size() < 9) begin
                    chk("spurious_beat", q.size(), 9);
                end else begin
                    for (int k = 0; k < 8; k++) chk($sformatf("lane%0d", k), o_l[k], q[k]);
                    chk("o_sat", o_sat, q[8]);
                    if (o_ready) repeat (9) void'(q.pop_front());
                end
            end
            if (i_valid && i_ready) begin
                longint x;
                longint anysat;
                anysat = 0;
                for (int k = 0; k < 8; k++) begin
                    x = rc(i_l[k], int'(i_shift));
                    if (x > 32767) begin x = 32767; anysat = 1; end
                    else if (x < -32768) begin x = -32768; anysat = 1; end
                    q.push_back(x);
                end
                q.push_back(anysat);
            end
        end
    end

    task automatic drive(input int sh, input longint a0, input longint a1,
                         input longint a2, input longint a3);
        i_shift = 4'(sh);
        i_l[0] = 28'(a0); i_l[1] = 28'(a1); i_l[2] = 28'(a2); i_l[3] = 28'(a3);
        for (int k = 4; k < 8; k++) i_l[k] = 28'(k * 37);
        i_valid = 1'b1;
        o_ready = 1'b1;
    endtask

    task automatic send_one(input int sh, input longint a0, input longint a1,
                            input longint a2, input longint a3);
        drive(sh, a0, a1, a2, a3);
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 2);
    endtask

    initial begin
        int sent, recv, c;
        for (int k = 0; k < 8; k++) i_l[k] = '0;
        #12;
        chk("reset_valid", o_valid, 0);
        chk("reset_sat", o_sat, 0);
        for (int k = 0; k < 8; k++) chk($sformatf("reset_lane%0d", k), o_l[k], 0);
        @(posedge clk); #1; rst = 1'b0;
        o_ready = 1'b1;
        @(posedge clk); #1;

        send_one(7, 1000, -1000, 0, 0);
        chk("t1_o0", o_l[0], 8);
        chk("t1_o1", o_l[1], -8);
        chk("t1_sat", o_sat, 0);

        send_one(0, 40000, -40000, 32767, 0);
        chk("t2_o0", o_l[0], 32767);
        chk("t2_o1", o_l[1], -32768);
        chk("t2_o2", o_l[2], 32767);
        chk("t2_sat", o_sat, 1);

        send_one(12, 2048, 2047, -2049, 134217727);
        chk("t4_o0", o_l[0], 1);
        chk("t4_o1", o_l[1], 0);
        chk("t4_o2", o_l[2], -1);
        chk("t4_o3", o_l[3], 32767);
        chk("t4_sat", o_sat, 1);
        @(posedge clk); #1;

        // Back-to-back stream with o_ready low on cycles 3..5.
        sent = 0; recv = 0; c = 0;
        while ((sent < 8 || recv < 8) && c < 60) begin
            @(posedge clk); #1;
            o_ready = !(c >= 3 && c <= 5);
            if (sent < 8) drive(7, sent * 1111 - 4000, -sent * 777, sent * 9000000, 63);
            else i_valid = 1'b0;
            o_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            if (c >= 3 && c <= 5 && o_valid) chk("stall_i_ready", i_ready, 0);
            if (i_valid && i_ready) sent++;
            if (o_valid && o_ready) recv++;
            c++;
        end
        chk("stream_sent", sent, 8);
        chk("stream_recv", recv, 8);
        @(posedge clk); #1; i_valid = 1'b0; o_ready = 1'b1;
        @(posedge clk); #1;

        // Reset with two beats in flight.
        drive(2, 500, 0, 0, 0);
        @(posedge clk); #1;
        drive(2, 600, 0, 0, 0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("pre_rst_valid", o_valid, 1);
        chk("pre_rst_o0", o_l[0], 125);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_o0", o_l[0], 0);
        chk("mid_rst_sat", o_sat, 0);
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", o_valid, 0);
        send_one(3, 13, -13, 0, 0);
        chk("t5_o0", o_l[0], 2);
        chk("t5_o1", o_l[1], -2);
        @(posedge clk); #1;

`ifdef TQ_ROUND_CLIP_SAT_CNT_EN
        for (int n = 0; n < 3; n++) begin
            send_one(0, 50000, 0, 0, 0);
        end
        @(posedge clk); #1;
        chk("t6_cnt3", o_sat_cnt, 3);
        send_one(0, -50000, 0, 0, 0);
        i_sat_clr = 1'b1;
        @(posedge clk); #1;
        i_sat_clr = 1'b0;
        chk("t6_clr", o_sat_cnt, 0);
        @(posedge clk); #1;
`endif

        // Randomised traffic with random backpressure and shift.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            i_valid = ($urandom_range(0, 3) != 0);
            o_ready = ($urandom_range(0, 3) != 0);
            i_shift = 4'($urandom_range(0, 15));
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(0, 3))
                    0: i_l[k] = 28'($urandom);
                    1: i_l[k] = 28'(int'($urandom_range(0, 8000)) - 4000);
                    2: i_l[k] = {1'b0, {27{1'b1}}};
                    default: i_l[k] = {1'b1, {27{1'b0}}};
                endcase
            end
`ifdef TQ_ROUND_CLIP_SAT_CNT_EN
            i_sat_clr = ($urandom_range(0, 19) == 0);
`endif
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        o_ready = 1'b1;
`ifdef TQ_ROUND_CLIP_SAT_CNT_EN
        i_sat_clr = 1'b0;
`endif
        repeat (6) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
        chk("drain_valid", o_valid, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
